// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_operand_stage
// Purpose  : ALU operand select/forward stage feeding a 2-entry output FIFO.
//            Optional macro ALU_OPERAND_FWD_EN enables EX/MEM bypass.
// Revision : 1.0 - initial release
// ============================================================================
module alu_operand_stage #(
   parameter int WIDTH = 16,
   parameter int IMMW  = 12,
   parameter int RIDX  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  pc,
   input  logic [WIDTH-1:0]  rs1_data,
   input  logic [WIDTH-1:0]  rs2_data,
   input  logic [RIDX-1:0]   rs1_idx,
   input  logic [RIDX-1:0]   rs2_idx,
   input  logic [IMMW-1:0]   imm_raw,
   input  logic              imm_sign,
   input  logic [1:0]        sel_a,
   input  logic [2:0]        sel_b,
   input  logic              fwd_ex_valid,
   input  logic              fwd_mem_valid,
   input  logic [RIDX-1:0]   fwd_ex_idx,
   input  logic [RIDX-1:0]   fwd_mem_idx,
   input  logic [WIDTH-1:0]  fwd_ex_data,
   input  logic [WIDTH-1:0]  fwd_mem_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  alu_a,
   output logic [WIDTH-1:0]  alu_b
);

   localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] w_ext;
   logic [WIDTH-1:0] w_r1;
   logic [WIDTH-1:0] w_r2;
   logic [WIDTH-1:0] w_op_a;
   logic [WIDTH-1:0] w_op_b;
   logic             w_push;
   logic             w_pop;

   logic [1:0]       count_q, count_d;
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_a_q [2];
   logic [WIDTH-1:0] mem_a_d [2];
   logic [WIDTH-1:0] mem_b_q [2];
   logic [WIDTH-1:0] mem_b_d [2];

   assign w_ext = {{(WIDTH-IMMW){imm_sign & imm_raw[IMMW-1]}}, imm_raw};

`ifdef ALU_OPERAND_FWD_EN
   // Register 0 is hard-wired, so it never takes a bypass value.
   always_comb begin
      w_r1 = rs1_data;
      if (rs1_idx != '0) begin
         if (fwd_ex_valid && (fwd_ex_idx == rs1_idx))
            w_r1 = fwd_ex_data;
         else if (fwd_mem_valid && (fwd_mem_idx == rs1_idx))
            w_r1 = fwd_mem_data;
      end
      w_r2 = rs2_data;
      if (rs2_idx != '0) begin
         if (fwd_ex_valid && (fwd_ex_idx == rs2_idx))
            w_r2 = fwd_ex_data;
         else if (fwd_mem_valid && (fwd_mem_idx == rs2_idx))
            w_r2 = fwd_mem_data;
      end
   end
`else
   logic w_unused_fwd;
   assign w_unused_fwd = ^{fwd_ex_valid, fwd_mem_valid, fwd_ex_idx, fwd_mem_idx,
                           fwd_ex_data, fwd_mem_data, rs1_idx, rs2_idx};
   assign w_r1 = rs1_data;
   assign w_r2 = rs2_data;
`endif

   always_comb begin
      w_op_a = C_ONE;
      case (sel_a)
         2'd0:    w_op_a = pc;
         2'd1:    w_op_a = w_r1;
         2'd2:    w_op_a = w_ext;
         default: w_op_a = C_ONE;
      endcase
      w_op_b = C_ONE;
      case (sel_b)
         3'd0:    w_op_b = w_r2;
         3'd2:    w_op_b = w_ext;
         3'd3:    w_op_b = {w_ext[WIDTH-2:0], 1'b0};
         3'd4:    w_op_b = {w_ext[WIDTH-3:0], 2'b00};
         default: w_op_b = C_ONE;
      endcase
   end

   // Ready depends only on the registered count, never on out_ready.
   assign in_ready  = (count_q != 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign w_push    = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;
   assign alu_a     = mem_a_q[rd_ptr_q];
   assign alu_b     = mem_b_q[rd_ptr_q];

   always_comb begin
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_a_d  = mem_a_q;
      mem_b_d  = mem_b_q;
      if (w_push) begin
         mem_a_d[wr_ptr_q] = w_op_a;
         mem_b_d[wr_ptr_q] = w_op_b;
         wr_ptr_d          = ~wr_ptr_q;
      end
      if (w_pop)
         rd_ptr_d = ~rd_ptr_q;
      case ({w_push, w_pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q    <= 2'd0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         mem_a_q[0] <= '0;
         mem_a_q[1] <= '0;
         mem_b_q[0] <= '0;
         mem_b_q[1] <= '0;
      end else begin
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         mem_a_q    <= mem_a_d;
         mem_b_q    <= mem_b_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_operand_stage
// Purpose  : Self-checking bench: directed literal cases plus random traffic
//            compared each cycle against a queue-based operand model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_operand_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] pc = '0, rs1_data = '0, rs2_data = '0;
   logic [3:0]  rs1_idx = '0, rs2_idx = '0;
   logic [11:0] imm_raw = '0;
   logic        imm_sign = 1'b0;
   logic [1:0]  sel_a = '0;
   logic [2:0]  sel_b = '0;
   logic        fwd_ex_valid = 1'b0, fwd_mem_valid = 1'b0;
   logic [3:0]  fwd_ex_idx = '0, fwd_mem_idx = '0;
   logic [15:0] fwd_ex_data = '0, fwd_mem_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] alu_a, alu_b;

   int n_total = 0;
   int n_pass  = 0;
   bit chk_en  = 1'b0;
   logic [31:0] q[$];

   alu_operand_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .imm_raw(imm_raw), .imm_sign(imm_sign),
      .sel_a(sel_a), .sel_b(sel_b),
      .fwd_ex_valid(fwd_ex_valid), .fwd_mem_valid(fwd_mem_valid),
      .fwd_ex_idx(fwd_ex_idx), .fwd_mem_idx(fwd_mem_idx),
      .fwd_ex_data(fwd_ex_data), .fwd_mem_data(fwd_mem_data),
      .out_valid(out_valid), .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [15:0] pick(input logic [3:0] idx, input logic [15:0] rf);
      logic [15:0] v;
      v = rf;
`ifdef ALU_OPERAND_FWD_EN
      if (idx != 0 && fwd_ex_valid && fwd_ex_idx == idx) v = fwd_ex_data;
      else if (idx != 0 && fwd_mem_valid && fwd_mem_idx == idx) v = fwd_mem_data;
`endif
      return v;
   endfunction

   // Operand pair {a,b} the stage must produce for the inputs currently applied.
   function automatic logic [31:0] model_ops();
      int e;
      logic [15:0] ext, a, b;
      e = int'(imm_raw);
      if (imm_sign && imm_raw >= 12'h800) e = e - 4096;
      ext = 16'(e);
      case (sel_a)
         2'd0: a = pc;
         2'd1: a = pick(rs1_idx, rs1_data);
         2'd2: a = ext;
         default: a = 16'd1;
      endcase
      case (sel_b)
         3'd0: b = pick(rs2_idx, rs2_data);
         3'd2: b = ext;
         3'd3: b = 16'(ext * 2);
         3'd4: b = 16'(ext * 4);
         default: b = 16'd1;
      endcase
      return {a, b};
   endfunction

   logic [31:0] m_ops;
   bit m_push, m_pop;
   always @(posedge clk or posedge rst) begin
      if (rst) q.delete();
      else begin
         m_push = in_valid && (q.size() < 2);
         m_pop  = out_ready && (q.size() > 0);
         m_ops  = model_ops();
         if (m_pop) void'(q.pop_front());
         if (m_push) q.push_back(m_ops);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
         chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
         if (q.size() > 0) begin
            chk("alu_a", {16'd0, alu_a}, {16'd0, q[0][31:16]});
            chk("alu_b", {16'd0, alu_b}, {16'd0, q[0][15:0]});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      step();
   endtask

   initial begin
      step();
      step();
      rst = 1'b0;
      chk_en = 1'b1;
      chk("rst out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst alu_a", {16'd0, alu_a}, 32'd0);
      chk("rst alu_b", {16'd0, alu_b}, 32'd0);

      // Basic pc / constant-one pair
      in_valid = 1'b1; out_ready = 1'b1; sel_a = 2'd0; pc = 16'h0100; sel_b = 3'd1;
      step();
      chk("pc out_valid", {31'd0, out_valid}, 32'd1);
      chk("pc alu_a", {16'd0, alu_a}, 32'h0100);
      chk("pc alu_b", {16'd0, alu_b}, 32'h0001);
      drain();

      // Immediate extension and shift
      in_valid = 1'b1; imm_raw = 12'hFFE; imm_sign = 1'b1; sel_b = 3'd3;
      step();
      chk("imm sext<<1", {16'd0, alu_b}, 32'hFFFC);
      drain();
      in_valid = 1'b1; imm_sign = 1'b0; sel_b = 3'd2;
      step();
      chk("imm zext", {16'd0, alu_b}, 32'h0FFE);
      drain();

      // Forwarding priority
      in_valid = 1'b1; sel_a = 2'd1; rs1_idx = 4'd3; rs1_data = 16'h5555;
      fwd_ex_valid = 1'b1; fwd_ex_idx = 4'd3; fwd_ex_data = 16'h1111;
      fwd_mem_valid = 1'b1; fwd_mem_idx = 4'd3; fwd_mem_data = 16'h2222;
      step();
`ifdef ALU_OPERAND_FWD_EN
      chk("fwd ex wins", {16'd0, alu_a}, 32'h1111);
`else
      chk("fwd disabled", {16'd0, alu_a}, 32'h5555);
`endif
      drain();
      in_valid = 1'b1; fwd_ex_valid = 1'b0;
      step();
`ifdef ALU_OPERAND_FWD_EN
      chk("fwd mem", {16'd0, alu_a}, 32'h2222);
`else
      chk("fwd mem disabled", {16'd0, alu_a}, 32'h5555);
`endif
      drain();
      in_valid = 1'b1; rs1_idx = 4'd0; fwd_ex_valid = 1'b1; fwd_ex_idx = 4'd0; fwd_mem_idx = 4'd0;
      step();
      chk("fwd idx0", {16'd0, alu_a}, 32'h5555);
      drain();
      fwd_ex_valid = 1'b0; fwd_mem_valid = 1'b0;

      // Back-pressure: A,B,C with out_ready low
      sel_a = 2'd0; sel_b = 3'd1; out_ready = 1'b0; in_valid = 1'b1;
      pc = 16'hAAAA; step();
      pc = 16'hBBBB; step();
      chk("full in_ready", {31'd0, in_ready}, 32'd0);
      pc = 16'hCCCC; step();
      chk("held head A", {16'd0, alu_a}, 32'hAAAA);
      out_ready = 1'b1; step();
      chk("order B", {16'd0, alu_a}, 32'hBBBB);
      step();
      chk("order C", {16'd0, alu_a}, 32'hCCCC);
      in_valid = 1'b0; step();
      chk("drained", {31'd0, out_valid}, 32'd0);

      // Asynchronous reset while full
      out_ready = 1'b0; in_valid = 1'b1;
      pc = 16'hEEEE; step();
      pc = 16'hFFFF; step();
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("async rst out_valid", {31'd0, out_valid}, 32'd0);
      chk("async rst in_ready", {31'd0, in_ready}, 32'd1);
      chk("async rst alu_a", {16'd0, alu_a}, 32'd0);
      #2 rst = 1'b0;
      pc = 16'hD00D; in_valid = 1'b1; out_ready = 1'b1;
      step();
      chk("post rst first", {16'd0, alu_a}, 32'hD00D);
      drain();

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         in_valid      = 1'($urandom_range(0, 1));
         out_ready     = ($urandom_range(0, 3) != 0);
         pc            = 16'($urandom);
         rs1_data      = 16'($urandom);
         rs2_data      = 16'($urandom);
         rs1_idx       = 4'($urandom_range(0, 3));
         rs2_idx       = 4'($urandom_range(0, 3));
         imm_raw       = 12'($urandom);
         imm_sign      = 1'($urandom_range(0, 1));
         sel_a         = 2'($urandom_range(0, 3));
         sel_b         = 3'($urandom_range(0, 7));
         fwd_ex_valid  = 1'($urandom_range(0, 1));
         fwd_mem_valid = 1'($urandom_range(0, 1));
         fwd_ex_idx    = 4'($urandom_range(0, 3));
         fwd_mem_idx   = 4'($urandom_range(0, 3));
         fwd_ex_data   = 16'($urandom);
         fwd_mem_data  = 16'($urandom);
         step();
      end
      drain();
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
